// File: rtl/key_pkg.sv
// Shared types and constants for the front-panel key scheduler.
`timescale 1ns/1ps
package key_pkg;

    localparam int unsigned KEY_N  = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned MODE_W = 2;
    localparam int unsigned GAIN_W = 3;
    localparam int unsigned CNT_W  = 25;

    localparam logic [SEL_W-1:0] KEY_MODE = 2'd0;
    localparam logic [SEL_W-1:0] KEY_UP   = 2'd1;
    localparam logic [SEL_W-1:0] KEY_DN   = 2'd2;
    localparam logic [SEL_W-1:0] KEY_RST  = 2'd3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HOLD      = 3'd1,
        APPLY     = 3'd2,
        WAIT_SYNC = 3'd3,
        HANDOFF   = 3'd4,
        WAIT_REL  = 3'd5
    } state_t;

    typedef struct packed {
        logic [MODE_W-1:0] mode;
        logic [GAIN_W-1:0] gain;
        logic              bypass;
    } cfg_t;

endpackage

// File: rtl/key_mode_sched_if.sv
// Configuration handoff bus between the key scheduler and the effect/gain stage.
`timescale 1ns/1ps
interface key_mode_sched_if;
    import key_pkg::*;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [MODE_W-1:0] cfg_mode;
    logic [GAIN_W-1:0] cfg_gain;
    logic              cfg_bypass;

    modport master (
        output cfg_valid,
        output cfg_mode,
        output cfg_gain,
        output cfg_bypass,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_mode,
        input  cfg_gain,
        input  cfg_bypass,
        output cfg_ready
    );

endinterface

// File: rtl/key_press_cls.sv
// Key press classifier: falling-edge detect, lowest-index priority select and
// hold timer producing a short/long event strobe for the selected key.
`timescale 1ns/1ps
module key_press_cls
    import key_pkg::*;
#(
    parameter int unsigned LONG_CNT = 25_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_N-1:0] key_deb,
    input  logic             arm,
    input  logic             hold,
    output logic             press_c,
    output logic             evt_c,
    output logic             evt_long_c,
    output logic             rel_c,
    output logic [SEL_W-1:0] sel
);

    logic [KEY_N-1:0] key_1d;
    logic [KEY_N-1:0] fall_c;
    logic [SEL_W-1:0] win_c;
    logic [CNT_W-1:0] hold_cnt;
    logic             at_long_c;

    assign fall_c = key_1d & ~key_deb;

    // Lowest pressed index wins; the others are dropped.
    always_comb begin
        win_c = '0;
        for (int i = KEY_N - 1; i >= 0; i--) begin
            if (fall_c[i]) win_c = SEL_W'(i);
        end
    end

    assign press_c    = arm & (|fall_c);
    assign rel_c      = key_deb[sel];
    assign at_long_c  = (hold_cnt == CNT_W'(LONG_CNT - 1));
    assign evt_c      = hold & (rel_c | at_long_c);
    assign evt_long_c = hold & ~rel_c & at_long_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_1d   <= '1;
            sel      <= '0;
            hold_cnt <= '0;
        end else begin
            key_1d <= key_deb;
            if (press_c) begin
                sel      <= win_c;
                hold_cnt <= '0;
            end else if (hold && !rel_c && !at_long_c) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_mode_sched.sv
// Key-driven effect configuration scheduler: maps key events to mode/gain/bypass
// and hands the new configuration to the datapath on a frame boundary.
`timescale 1ns/1ps
module key_mode_sched
    import key_pkg::*;
#(
    parameter int unsigned LONG_CNT = 25_000_000,
    parameter int unsigned MODE_NUM = 4,
    parameter int unsigned GAIN_MAX = 7,
    parameter int unsigned GAIN_DEF = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [KEY_N-1:0]        key_deb,
    input  logic                    frame_sync,
    key_mode_sched_if.master        cfg_if,
    output logic                    busy
);

    localparam cfg_t CFG_DEF = '{mode: '0, gain: GAIN_W'(GAIN_DEF), bypass: 1'b0};

    state_t           state_q, state_d;
    cfg_t             cfg_q, cfg_d;
    cfg_t             shadow_q, shadow_d;
    cfg_t             apply_c;
    logic             long_q, long_d;
    logic             valid_q, valid_d;
    logic             busy_q;
    logic             press_c, evt_c, evt_long_c, rel_c;
    logic [SEL_W-1:0] sel;

    key_press_cls #(.LONG_CNT(LONG_CNT)) u_cls (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_deb    (key_deb),
        .arm        (state_q == IDLE),
        .hold       (state_q == HOLD),
        .press_c    (press_c),
        .evt_c      (evt_c),
        .evt_long_c (evt_long_c),
        .rel_c      (rel_c),
        .sel        (sel)
    );

    // Configuration that a classified event produces from the current one.
    function automatic cfg_t next_cfg(cfg_t cur, logic [SEL_W-1:0] key, logic is_long);
        cfg_t n;
        n = cur;
        unique case (key)
            KEY_MODE: begin
                if (is_long) n.bypass = ~cur.bypass;
                else         n.mode = (cur.mode == MODE_W'(MODE_NUM - 1)) ? '0
                                                                          : cur.mode + MODE_W'(1);
            end
            KEY_UP:  if (cur.gain < GAIN_W'(GAIN_MAX)) n.gain = cur.gain + GAIN_W'(1);
            KEY_DN:  if (cur.gain != '0)               n.gain = cur.gain - GAIN_W'(1);
            KEY_RST: n = CFG_DEF;
        endcase
        return n;
    endfunction

    assign apply_c = next_cfg(cfg_q, sel, long_q);

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        shadow_d = shadow_q;
        long_d   = long_q;
        valid_d  = valid_q;
        unique case (state_q)
            IDLE:      if (press_c) state_d = HOLD;
            HOLD: begin
                if (evt_c) begin
                    long_d  = evt_long_c;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                shadow_d = apply_c;
                state_d  = (apply_c == cfg_q) ? WAIT_REL : WAIT_SYNC;
            end
            WAIT_SYNC: begin
                if (frame_sync) begin
                    cfg_d   = shadow_q;
                    valid_d = 1'b1;
                    state_d = HANDOFF;
                end
            end
            HANDOFF: begin
                if (valid_q && cfg_if.cfg_ready) begin
                    valid_d = 1'b0;
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL:  if (rel_c) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cfg_q    <= CFG_DEF;
            shadow_q <= CFG_DEF;
            long_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            shadow_q <= shadow_d;
            long_q   <= long_d;
            valid_q  <= valid_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    assign cfg_if.cfg_valid  = valid_q;
    assign cfg_if.cfg_mode   = cfg_q.mode;
    assign cfg_if.cfg_gain   = cfg_q.gain;
    assign cfg_if.cfg_bypass = cfg_q.bypass;
    assign busy              = busy_q;

endmodule

// File: tb/tb_key_mode_sched.sv
// Directed bench for key_mode_sched with a shortened long-press threshold.
`timescale 1ns/1ps
module tb_key_mode_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_deb;
    logic       frame_sync;
    logic       busy;
    int         tests  = 0;
    int         failed = 0;

    key_mode_sched_if bus ();

    key_mode_sched #(.LONG_CNT(1000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_deb    (key_deb),
        .frame_sync (frame_sync),
        .cfg_if     (bus),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_release(input logic [1:0] k, input int n);
        key_deb[k] = 1'b0;
        repeat (n) step();
        key_deb[k] = 1'b1;
    endtask

    task automatic pulse_sync();
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_deb = 4'b1111;
        frame_sync = 1'b0;
        bus.cfg_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        tests++; if (bus.cfg_mode !== 2'd0) begin failed++; $display("FAIL reset_mode: got %0d exp 0", bus.cfg_mode); end
        tests++; if (bus.cfg_gain !== 3'd3) begin failed++; $display("FAIL reset_gain: got %0d exp 3", bus.cfg_gain); end
        tests++; if (bus.cfg_bypass !== 1'b0) begin failed++; $display("FAIL reset_bypass: got %b exp 0", bus.cfg_bypass); end
        tests++; if (bus.cfg_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b exp 0", bus.cfg_valid); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b exp 0", busy); end
    endtask

    task automatic test_mode_wrap();
        logic [1:0] exp_mode;
        bus.cfg_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_mode = 2'((i + 1) % 4);
            press_release(2'd0, 100);
            repeat (3) step();
            tests++; if ({busy, bus.cfg_valid} !== 2'b10) begin failed++; $display("FAIL mode_wait%0d: busy/valid got %b exp 10", i, {busy, bus.cfg_valid}); end
            pulse_sync();
            tests++; if (bus.cfg_valid !== 1'b1) begin failed++; $display("FAIL mode_valid%0d: got %b exp 1", i, bus.cfg_valid); end
            tests++; if (bus.cfg_mode !== exp_mode) begin failed++; $display("FAIL mode_val%0d: got %0d exp %0d", i, bus.cfg_mode, exp_mode); end
            step();
            tests++; if (bus.cfg_valid !== 1'b0) begin failed++; $display("FAIL mode_drop%0d: got %b exp 0", i, bus.cfg_valid); end
            repeat (2) step();
            tests++; if (busy !== 1'b0) begin failed++; $display("FAIL mode_idle%0d: busy got %b exp 0", i, busy); end
        end
    endtask

    task automatic test_long_press();
        key_deb[0] = 1'b0;
        repeat (1000) step();
        pulse_sync();
        tests++; if (bus.cfg_valid !== 1'b0) begin failed++; $display("FAIL long_early_hold: valid got %b exp 0", bus.cfg_valid); end
        pulse_sync();
        tests++; if (bus.cfg_valid !== 1'b0) begin failed++; $display("FAIL long_early_apply: valid got %b exp 0", bus.cfg_valid); end
        pulse_sync();
        tests++; if (bus.cfg_valid !== 1'b1) begin failed++; $display("FAIL long_valid: got %b exp 1", bus.cfg_valid); end
        tests++; if ({bus.cfg_mode, bus.cfg_gain, bus.cfg_bypass} !== {2'd0, 3'd3, 1'b1}) begin
            failed++; $display("FAIL long_cfg: mode %0d gain %0d byp %b exp 0 3 1", bus.cfg_mode, bus.cfg_gain, bus.cfg_bypass);
        end
        step();
        tests++; if (bus.cfg_valid !== 1'b0) begin failed++; $display("FAIL long_drop: got %b exp 0", bus.cfg_valid); end
        repeat (900) step();
        pulse_sync();
        tests++; if ({busy, bus.cfg_valid} !== 2'b10) begin failed++; $display("FAIL long_no_repeat: busy/valid got %b exp 10", {busy, bus.cfg_valid}); end
        tests++; if (bus.cfg_bypass !== 1'b1) begin failed++; $display("FAIL long_byp_hold: got %b exp 1", bus.cfg_bypass); end
        key_deb[0] = 1'b1;
        repeat (3) step();
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL long_release: busy got %b exp 0", busy); end
    endtask

    task automatic test_gain_sat();
        for (int i = 0; i < 4; i++) begin
            press_release(2'd1, 10);
            repeat (3) step();
            pulse_sync();
            tests++; if (bus.cfg_valid !== 1'b1) begin failed++; $display("FAIL gain_valid%0d: got %b exp 1", i, bus.cfg_valid); end
            tests++; if (bus.cfg_gain !== 3'(4 + i)) begin failed++; $display("FAIL gain_step%0d: got %0d exp %0d", i, bus.cfg_gain, 4 + i); end
            step();
            repeat (2) step();
        end
        press_release(2'd1, 10);
        repeat (3) step();
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL gain_sat_busy: got %b exp 0", busy); end
        pulse_sync();
        tests++; if (bus.cfg_valid !== 1'b0) begin failed++; $display("FAIL gain_sat_valid: got %b exp 0", bus.cfg_valid); end
        tests++; if (bus.cfg_gain !== 3'd7) begin failed++; $display("FAIL gain_sat_val: got %0d exp 7", bus.cfg_gain); end
    endtask

    task automatic test_key_reset();
        press_release(2'd3, 10);
        repeat (3) step();
        pulse_sync();
        tests++; if (bus.cfg_valid !== 1'b1) begin failed++; $display("FAIL key3_valid: got %b exp 1", bus.cfg_valid); end
        tests++; if ({bus.cfg_mode, bus.cfg_gain, bus.cfg_bypass} !== {2'd0, 3'd3, 1'b0}) begin
            failed++; $display("FAIL key3_cfg: mode %0d gain %0d byp %b exp 0 3 0", bus.cfg_mode, bus.cfg_gain, bus.cfg_bypass);
        end
        step();
        repeat (2) step();
    endtask

    task automatic test_simultaneous();
        key_deb[1] = 1'b0;
        key_deb[2] = 1'b0;
        repeat (10) step();
        key_deb = 4'b1111;
        repeat (3) step();
        pulse_sync();
        tests++; if ({bus.cfg_valid, bus.cfg_gain} !== {1'b1, 3'd4}) begin
            failed++; $display("FAIL simul_prio: valid %b gain %0d exp 1 4", bus.cfg_valid, bus.cfg_gain);
        end
        step();
        repeat (2) step();
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL simul_idle: busy got %b exp 0", busy); end
        pulse_sync();
        tests++; if ({bus.cfg_valid, bus.cfg_gain} !== {1'b0, 3'd4}) begin
            failed++; $display("FAIL simul_no_queue: valid %b gain %0d exp 0 4", bus.cfg_valid, bus.cfg_gain);
        end
        press_release(2'd2, 10);
        repeat (3) step();
        pulse_sync();
        tests++; if ({bus.cfg_valid, bus.cfg_gain} !== {1'b1, 3'd3}) begin
            failed++; $display("FAIL gain_down: valid %b gain %0d exp 1 3", bus.cfg_valid, bus.cfg_gain);
        end
        step();
        repeat (2) step();
    endtask

    task automatic test_stall_reset();
        bus.cfg_ready = 1'b0;
        press_release(2'd0, 10);
        repeat (3) step();
        pulse_sync();
        tests++; if ({bus.cfg_valid, bus.cfg_mode} !== {1'b1, 2'd1}) begin
            failed++; $display("FAIL stall_start: valid %b mode %0d exp 1 1", bus.cfg_valid, bus.cfg_mode);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            tests++;
            if ({bus.cfg_valid, bus.cfg_mode, bus.cfg_gain, bus.cfg_bypass} !== {1'b1, 2'd1, 3'd3, 1'b0}) begin
                failed++;
                $display("FAIL stall_hold%0d: valid %b mode %0d gain %0d byp %b exp 1 1 3 0",
                         c, bus.cfg_valid, bus.cfg_mode, bus.cfg_gain, bus.cfg_bypass);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if ({bus.cfg_valid, busy} !== 2'b00) begin failed++; $display("FAIL async_rst_valid: valid/busy got %b exp 00", {bus.cfg_valid, busy}); end
        tests++; if ({bus.cfg_mode, bus.cfg_gain, bus.cfg_bypass} !== {2'd0, 3'd3, 1'b0}) begin
            failed++; $display("FAIL async_rst_cfg: mode %0d gain %0d byp %b exp 0 3 0", bus.cfg_mode, bus.cfg_gain, bus.cfg_bypass);
        end
        repeat (2) step();
        rst_n = 1'b1;
        bus.cfg_ready = 1'b1;
        repeat (3) step();
        tests++; if ({bus.cfg_valid, busy, bus.cfg_mode} !== {1'b0, 1'b0, 2'd0}) begin
            failed++; $display("FAIL post_rst: valid %b busy %b mode %0d exp 0 0 0", bus.cfg_valid, busy, bus.cfg_mode);
        end
    endtask

    initial begin
        test_reset();
        test_mode_wrap();
        test_long_press();
        test_gain_sat();
        test_key_reset();
        test_simultaneous();
        test_stall_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
